// File: rtl/switch_allocator.sv
// Switch allocator: per-output round-robin arbitration of single-output requests,
// with reservations held until the owning input port relieves them.
module switch_allocator #(
  parameter int N             = 4,
  parameter int REQUEST_WIDTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N-1:0]               routeReserveRequestValid,
  input  logic [N*REQUEST_WIDTH-1:0] routeReserveRequest,
  input  logic [N-1:0]               routeRelieve,
  output logic [N-1:0]               routeReserveStatus,
  output logic [N-1:0]               outputBusy,
  output logic [N*REQUEST_WIDTH-1:0] outputSelect
);

  localparam int RW = REQUEST_WIDTH;

  typedef enum logic {
    FREE     = 1'b0,
    RESERVED = 1'b1
  } out_state_e;

  out_state_e    state_q [N];
  out_state_e    state_d [N];
  logic [RW-1:0] owner_q [N];
  logic [RW-1:0] owner_d [N];
  logic [RW-1:0] ptr_q   [N];
  logic [RW-1:0] ptr_d   [N];
  logic [N-1:0]  status_q;
  logic [N-1:0]  status_d;

  logic [RW-1:0] req_idx [N];
  logic [N-1:0]  eligible;

  // A port that already owns an output, or names a nonexistent one, never competes.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < N; i++) begin
      req_idx[i]  = routeReserveRequest[i*RW +: RW];
      eligible[i] = routeReserveRequestValid[i] && !status_q[i] && (int'(req_idx[i]) < N);
    end
  end

  always_comb begin : alloc
    logic found;
    int   idx;
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    status_d = status_q;
    found    = 1'b0;
    idx      = 0;
    for (int o = 0; o < N; o++) begin
      state_d[o] = state_q[o];
      owner_d[o] = owner_q[o];
      ptr_d[o]   = ptr_q[o];
    end

    for (int o = 0; o < N; o++) begin
      if (state_q[o] == RESERVED) begin
        // Release takes the whole edge; the output is only re-arbitrated on the next one.
        for (int p = 0; p < N; p++) begin
          if (owner_q[o] == RW'(p) && routeRelieve[p]) begin
            state_d[o]  = FREE;
            owner_d[o]  = '0;
            status_d[p] = 1'b0;
          end
        end
      end else begin
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
          idx = int'(ptr_q[o]) + k;
          if (idx >= N) idx = idx - N;
          if (!found && eligible[idx] && req_idx[idx] == RW'(o)) begin
            found         = 1'b1;
            state_d[o]    = RESERVED;
            owner_d[o]    = RW'(idx);
            ptr_d[o]      = (idx == N - 1) ? '0 : RW'(idx + 1);
            status_d[idx] = 1'b1;
          end
        end
      end
    end
  end

  // NOTE: the per-output arrays are reset too, because arbitration must restart from pointer 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int o = 0; o < N; o++) begin
        state_q[o] <= FREE;
        owner_q[o] <= '0;
        ptr_q[o]   <= '0;
      end
      status_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      for (int o = 0; o < N; o++) begin
        state_q[o] <= state_d[o];
        owner_q[o] <= owner_d[o];
        ptr_q[o]   <= ptr_d[o];
      end
      status_q <= status_d;
    end
  end

  always_comb begin
    outputBusy   = '0;
    outputSelect = '0;
    for (int o = 0; o < N; o++) begin
      outputBusy[o]              = (state_q[o] == RESERVED);
      outputSelect[o*RW +: RW]   = owner_q[o];
    end
  end

  assign routeReserveStatus = status_q;

endmodule

// File: tb/tb_switch_allocator.sv
// Directed bench for switch_allocator: an N=4 instance for the main scenarios and an
// N=3 instance for out-of-range request indices.
module tb_switch_allocator;

  logic       clk;
  logic       rst;

  logic [3:0] valid4, relieve4, status4, busy4;
  logic [7:0] req4, sel4;

  logic [2:0] valid3, relieve3, status3, busy3;
  logic [5:0] req3, sel3;

  int checks;
  int errors;

  switch_allocator #(.N(4), .REQUEST_WIDTH(2)) dut4 (
    .clk                      (clk),
    .rst                      (rst),
    .routeReserveRequestValid (valid4),
    .routeReserveRequest      (req4),
    .routeRelieve             (relieve4),
    .routeReserveStatus       (status4),
    .outputBusy               (busy4),
    .outputSelect             (sel4)
  );

  switch_allocator #(.N(3), .REQUEST_WIDTH(2)) dut3 (
    .clk                      (clk),
    .rst                      (rst),
    .routeReserveRequestValid (valid3),
    .routeReserveRequest      (req3),
    .routeRelieve             (relieve3),
    .routeReserveStatus       (status3),
    .outputBusy               (busy3),
    .outputSelect             (sel3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    valid4 = '0; req4 = '0; relieve4 = '0;
    valid3 = '0; req3 = '0; relieve3 = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    valid4 = '0; req4 = '0; relieve4 = '0;
    valid3 = '0; req3 = '0; relieve3 = '0;
    rst = 1'b1;
    #1;
    checks++; if (status4 !== 4'b0000) begin errors++; $display("FAIL reset_status got %b exp %b", status4, 4'b0000); end
    checks++; if (busy4 !== 4'b0000) begin errors++; $display("FAIL reset_busy got %b exp %b", busy4, 4'b0000); end
    checks++; if (sel4 !== 8'h00) begin errors++; $display("FAIL reset_select got %h exp %h", sel4, 8'h00); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_single_grant();
    do_reset();
    valid4 = 4'b0010; req4 = 8'b00_00_10_00;
    tick();
    checks++; if (status4 !== 4'b0010) begin errors++; $display("FAIL single_status got %b exp %b", status4, 4'b0010); end
    checks++; if (busy4 !== 4'b0100) begin errors++; $display("FAIL single_busy got %b exp %b", busy4, 4'b0100); end
    checks++; if (sel4 !== 8'h10) begin errors++; $display("FAIL single_select got %h exp %h", sel4, 8'h10); end
    // Owner keeps requesting a different output: reservation must not move.
    req4 = 8'b00_00_11_00;
    tick();
    checks++; if (busy4 !== 4'b0100) begin errors++; $display("FAIL single_hold_busy got %b exp %b", busy4, 4'b0100); end
    valid4 = '0; relieve4 = 4'b0010;
    tick();
    relieve4 = '0;
    checks++; if (status4 !== 4'b0000) begin errors++; $display("FAIL single_release_status got %b exp %b", status4, 4'b0000); end
    checks++; if (busy4 !== 4'b0000) begin errors++; $display("FAIL single_release_busy got %b exp %b", busy4, 4'b0000); end
    checks++; if (sel4 !== 8'h00) begin errors++; $display("FAIL single_release_select got %h exp %h", sel4, 8'h00); end
  endtask

  task automatic test_round_robin();
    int exp_owner [4] = '{0, 3, 0, 3};
    logic [3:0] exp_status;
    do_reset();
    valid4 = 4'b1001; req4 = 8'b01_00_00_01;
    for (int r = 0; r < 4; r++) begin
      tick();
      exp_status = 4'b0001 << exp_owner[r];
      checks++; if (status4 !== exp_status) begin errors++; $display("FAIL rr_status round %0d got %b exp %b", r, status4, exp_status); end
      checks++; if (sel4[3:2] !== 2'(exp_owner[r])) begin errors++; $display("FAIL rr_owner round %0d got %0d exp %0d", r, sel4[3:2], exp_owner[r]); end
      tick();
      relieve4 = exp_status;
      tick();
      relieve4 = '0;
      checks++; if (busy4[1] !== 1'b0) begin errors++; $display("FAIL rr_no_same_edge_regrant round %0d got %b exp 0", r, busy4[1]); end
    end
    valid4 = '0;
  endtask

  task automatic test_parallel();
    do_reset();
    valid4 = 4'b1111; req4 = 8'b00_01_10_11;
    tick();
    checks++; if (status4 !== 4'b1111) begin errors++; $display("FAIL par_status got %b exp %b", status4, 4'b1111); end
    checks++; if (busy4 !== 4'b1111) begin errors++; $display("FAIL par_busy got %b exp %b", busy4, 4'b1111); end
    checks++; if (sel4 !== 8'h1B) begin errors++; $display("FAIL par_select got %h exp %h", sel4, 8'h1B); end
    valid4 = '0; relieve4 = 4'b1111;
    tick();
    relieve4 = '0;
    checks++; if (busy4 !== 4'b0000) begin errors++; $display("FAIL par_release_busy got %b exp %b", busy4, 4'b0000); end
  endtask

  task automatic test_release_regrant();
    do_reset();
    valid4 = 4'b0100; req4 = 8'b00_00_00_00;
    tick();
    checks++; if (sel4 !== 8'h02) begin errors++; $display("FAIL rg_first_select got %h exp %h", sel4, 8'h02); end
    valid4 = 4'b0110;
    tick();
    checks++; if (status4 !== 4'b0100) begin errors++; $display("FAIL rg_wait_status got %b exp %b", status4, 4'b0100); end
    valid4 = 4'b0010; relieve4 = 4'b0100;
    tick();
    relieve4 = '0;
    checks++; if (busy4 !== 4'b0000) begin errors++; $display("FAIL rg_release_busy got %b exp %b", busy4, 4'b0000); end
    checks++; if (status4 !== 4'b0000) begin errors++; $display("FAIL rg_release_status got %b exp %b", status4, 4'b0000); end
    tick();
    checks++; if (status4 !== 4'b0010) begin errors++; $display("FAIL rg_regrant_status got %b exp %b", status4, 4'b0010); end
    checks++; if (sel4 !== 8'h01) begin errors++; $display("FAIL rg_regrant_select got %h exp %h", sel4, 8'h01); end
    valid4 = '0;
  endtask

  task automatic test_illegal();
    do_reset();
    valid3 = 3'b001; req3 = 6'b00_00_11;
    tick();
    checks++; if (status3 !== 3'b000) begin errors++; $display("FAIL ill_oob_status got %b exp %b", status3, 3'b000); end
    checks++; if (busy3 !== 3'b000) begin errors++; $display("FAIL ill_oob_busy got %b exp %b", busy3, 3'b000); end
    valid3 = 3'b011; req3 = 6'b00_00_11;
    tick();
    checks++; if (status3 !== 3'b010) begin errors++; $display("FAIL ill_legal_status got %b exp %b", status3, 3'b010); end
    relieve3 = 3'b100;
    tick();
    tick();
    relieve3 = '0;
    checks++; if (status3 !== 3'b010) begin errors++; $display("FAIL ill_spurious_status got %b exp %b", status3, 3'b010); end
    checks++; if (busy3 !== 3'b001) begin errors++; $display("FAIL ill_spurious_busy got %b exp %b", busy3, 3'b001); end
    checks++; if (sel3 !== 6'h01) begin errors++; $display("FAIL ill_spurious_select got %h exp %h", sel3, 6'h01); end
    valid3 = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    valid4 = 4'b1001; req4 = 8'b10_00_00_01;
    tick();
    checks++; if (busy4 !== 4'b0110) begin errors++; $display("FAIL rm_pre_busy got %b exp %b", busy4, 4'b0110); end
    #2 rst = 1'b1;
    #1;
    checks++; if (status4 !== 4'b0000) begin errors++; $display("FAIL rm_async_status got %b exp %b", status4, 4'b0000); end
    checks++; if (busy4 !== 4'b0000) begin errors++; $display("FAIL rm_async_busy got %b exp %b", busy4, 4'b0000); end
    checks++; if (sel4 !== 8'h00) begin errors++; $display("FAIL rm_async_select got %h exp %h", sel4, 8'h00); end
    rst = 1'b0;
    tick();
    checks++; if (status4 !== 4'b1001) begin errors++; $display("FAIL rm_regrant_status got %b exp %b", status4, 4'b1001); end
    checks++; if (sel4 !== 8'h30) begin errors++; $display("FAIL rm_regrant_select got %h exp %h", sel4, 8'h30); end
    valid4 = '0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_grant();
    test_round_robin();
    test_parallel();
    test_release_regrant();
    test_illegal();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
